mul: RTL and testbench

//  Sequential radix-2 shift-add unsigned multiplier; companion to the 27-bit div unit.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_acc_step.sv | 17 +
 rtl/mul.sv | 94 +++++++++
 tb/tb_mul.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM encoding and sizing helpers for the mul/div sequencers
package mul_pkg;

  localparam int WIDTH_DEF = 27;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width for an arbitrary operand width (never zero bits)
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mul_acc_step.sv
// rtl/mul_acc_step.sv - one combinational shift-add iteration of the radix-2 multiplier
module mul_acc_step #(
  parameter int WIDTH = 27
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [2*WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [2*WIDTH-1:0] a_out,
  output logic [WIDTH-1:0]   b_out
);

  assign acc_out = b_in[0] ? (acc_in + a_in) : acc_in;
  assign a_out   = a_in << 1;
  assign b_out   = b_in >> 1;

endmodule

// File: rtl/mul.sv
// rtl/mul.sv - sequential shift-add unsigned multiplier with start/complete/overflow handshake
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is all zero.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int FRAC  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_product_out,
  output logic             o_complete,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] a_nx;
  logic [WIDTH-1:0]   b_nx;
  logic [2*WIDTH-1:0] full_shr;
  logic               last_iter;

  mul_acc_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .a_in    (a_reg),
    .b_in    (b_reg),
    .acc_out (acc_nx),
    .a_out   (a_nx),
    .b_out   (b_nx)
  );

  // Result window is taken from the value the final iteration produces
  assign full_shr = acc_nx >> FRAC;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (cnt == LAST) || (b_nx == '0);
`else
  assign last_iter = (cnt == LAST);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      acc           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      cnt           <= '0;
      o_product_out <= '0;
      o_complete    <= 1'b0;
      o_overflow    <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            a_reg      <= {{WIDTH{1'b0}}, i_multiplicand};
            b_reg      <= i_multiplier;
            acc        <= '0;
            cnt        <= '0;
            o_complete <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_nx;
          a_reg <= a_nx;
          b_reg <= b_nx;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            o_product_out <= full_shr[WIDTH-1:0];
            o_overflow    <= |full_shr[2*WIDTH-1:WIDTH];
            o_complete    <= 1'b1;
            o_busy        <= 1'b0;
            state         <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
// tb/tb_mul.sv - scoreboard bench for mul (FRAC=0 and FRAC=8 instances)
module tb_mul;
  import mul_pkg::*;

  localparam int W = 27;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, prod;
  logic         start, cpl, ovf, busy;
  logic [W-1:0] fa, fb, fprod;
  logic         fstart, fcpl, fovf, fbusy;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul #(.WIDTH(W), .FRAC(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_multiplicand(a), .i_multiplier(b), .i_start(start),
    .o_product_out(prod), .o_complete(cpl), .o_overflow(ovf), .o_busy(busy)
  );

  mul #(.WIDTH(W), .FRAC(8)) dut_f (
    .i_clk(clk), .i_rst(rst), .i_multiplicand(fa), .i_multiplier(fb), .i_start(fstart),
    .o_product_out(fprod), .o_complete(fcpl), .o_overflow(fovf), .o_busy(fbusy)
  );

  typedef struct packed {
    logic [W-1:0] p;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int frac);
    logic [2*W-1:0] full;
    exp_t e;
    full = (2*W)'(x) * (2*W)'(y);
    full = full >> frac;
    e.p  = full[W-1:0];
    e.ov = |full[2*W-1:W];
    return e;
  endfunction

  // Cycles from the cycle i_start is driven to the first cycle o_complete is seen
  function automatic int exp_lat(input logic [W-1:0] y);
    int k;
    k = W - 1;
`ifdef MUL_EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < W; i++) if (y[i]) k = i;
`endif
    return k + 2;
  endfunction

  task automatic do_mul(input logic [W-1:0] av, input logic [W-1:0] bv, input int poke);
    exp_t e;
    int   lat;
    bit   busy_ok;
    sb.push_back(model(av, bv, 0));
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    while (lat < 200) begin
      @(negedge clk);
      if (cpl) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == poke) begin
        start = 1'b1; a = 100; b = 100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat(bv));
    check("busy_run", busy_ok, 1);
    check("busy_done", busy, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("product", prod, e.p);
      check("overflow", ovf, e.ov);
    end else begin
      check("scoreboard_empty", 1, 0);
    end
  endtask

  task automatic do_frac(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   t;
    e = model(av, bv, 8);
    @(negedge clk);
    fa = av; fb = bv; fstart = 1'b1;
    @(posedge clk);
    #1 fstart = 1'b0;
    t = 0;
    while (!fcpl && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    check("frac_complete", fcpl, 1);
    check("frac_product", fprod, e.p);
    check("frac_overflow", fovf, e.ov);
  endtask

  initial begin
    logic [W-1:0] sa, sbv;
    int t, r1, r2;

    rst = 1'b1; a = '0; b = '0; start = 1'b0;
    fa = '0; fb = '0; fstart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_product", prod, 0);
    check("rst_complete", cpl, 0);
    check("rst_overflow", ovf, 0);
    check("rst_busy", busy, 0);

    // Abort a running 9*3 with an asynchronous reset between clock edges
    @(negedge clk);
    a = 9; b = 3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrun_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_complete", cpl, 0);
    check("abort_product", prod, 0);
    check("abort_overflow", ovf, 0);
    check("abort_state", 64'(dut.state), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    do_mul(9, 3, 0);
    do_mul(16, 4, 0);
    do_mul(15, 5, 0);
    do_mul(27'h7FFFFFF, 2, 0);
    do_mul(27'h4000, 27'h2000, 0);
    do_mul(0, 27'h12345, 0);
    do_mul(27'h12345, 0, 0);
    do_mul(27'h5A5, 1, 0);
    do_mul(5, 7, 10);

    do_frac(3 << 8, 2 << 8);
    do_frac(27'h7FFFFFF, 27'h7FFFFFF);

    sa = 1; sbv = 1;
    for (int i = 0; i < 12; i++) begin
      do_mul(sa, sbv, 0);
      sa  = (sa << 1) + 3;
      sbv = (sbv << 1) + 1;
      repeat (4) @(posedge clk);
    end

    // i_start held high: back-to-back restarts with a fixed period
    @(negedge clk);
    a = 3; b = 5; start = 1'b1;
    @(posedge clk);
    t = 0;
    #1;
    while (!cpl && t < 200) begin @(posedge clk); #1 t++; end
    r1 = cyc;
    check("held_product", prod, 15);
    t = 0;
    while (cpl && t < 200) begin @(posedge clk); #1 t++; end
    t = 0;
    while (!cpl && t < 200) begin @(posedge clk); #1 t++; end
    r2 = cyc;
    check("held_period", r2 - r1, exp_lat(5));
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!cpl && t < 200) begin @(posedge clk); #1 t++; end
    check("held_settle", cpl, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
